// File: rtl/cpu_control_fsm_pkg.sv
// Shared types and constants for the multicycle CPU controller.
// States, ALU ops, ARM cmd/cond codes and datapath mux selects.
package cpu_ctrl_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int FLAGS_W    = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB,
    MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  function automatic logic [ALU_CTRL_W-1:0] alu_op(
    input logic [3:0] cmd
  );
    unique case (cmd)
      CMD_SUB, CMD_CMP: alu_op = ALU_SUB;
      CMD_AND:          alu_op = ALU_AND;
      CMD_ORR:          alu_op = ALU_ORR;
      default:          alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Controller <-> datapath bundle: IR/flags in, enables and selects out.
interface cpu_control_fsm_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]           instr;
  logic [FLAGS_W-1:0]    alu_flags;
  logic                  pc_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [FLAGS_W-1:0]    flags_q;
  logic                  illegal_instr;
  logic [3:0]            state_dbg;

  modport master (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_write,
    output ir_write, reg_write,
    output alu_src_a, alu_src_b, result_src,
    output alu_control, flags_q,
    output illegal_instr, state_dbg
  );

  modport slave (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_write,
    input  ir_write, reg_write,
    input  alu_src_a, alu_src_b, result_src,
    input  alu_control, flags_q,
    input  illegal_instr, state_dbg
  );

endinterface

// File: rtl/cpu_control_fsm_cond_unit.sv
// ARM condition-code evaluator; flags ordered N,Z,C,V (MSB..LSB).
module cond_unit
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]         cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle main controller: sequences FETCH..WRITEBACK,
// drives datapath enables/selects and owns the NZCV register.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
(
  input logic             clk,
  input logic             reset,
  cpu_control_fsm_if.master ctrl
);

  state_t state, state_n;
  logic [FLAGS_W-1:0] flags_r, flags_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd, rd;
  logic is_cmp, arith, cmd_ok;
  logic dp_bad, ld_bad, cond_ex;
  logic unused_bits;

  assign op     = ctrl.instr[27:26];
  assign funct  = ctrl.instr[25:20];
  assign cmd    = funct[4:1];
  assign rd     = ctrl.instr[15:12];
  assign is_cmp = (cmd == CMD_CMP);
  assign arith  = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;
  assign cmd_ok = arith || (cmd == CMD_AND) || (cmd == CMD_ORR);
  // PC writeback is unsupported: reject it up front in DECODE
  assign dp_bad = !cmd_ok || ((rd == 4'hF) && !is_cmp);
  assign ld_bad = (rd == 4'hF) && funct[0];
  assign unused_bits = ^{ctrl.instr[19:16], ctrl.instr[11:0]};

  cond_unit u_cond (
    .cond    (ctrl.instr[31:28]),
    .flags   (flags_r),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags_r <= '0;
    end else begin
      state   <= state_n;
      flags_r <= flags_d;
    end
  end

  always_comb begin
    state_n            = state;
    flags_d            = flags_r;
    ctrl.pc_write      = 1'b0;
    ctrl.adr_src       = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.alu_src_a     = SRCA_REG;
    ctrl.alu_src_b     = SRCB_REG;
    ctrl.result_src    = RES_ALUOUT;
    ctrl.alu_control   = ALU_ADD;
    ctrl.illegal_instr = 1'b0;
    unique case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        state_n         = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        state_n        = FETCH;
        if (cond_ex) begin
          unique case (1'b1)
            (op == OP_DP) && !dp_bad:
              state_n = funct[5] ? EXECI : EXECR;
            (op == OP_MEM) && !ld_bad:
              state_n = MEMADR;
            (op == OP_BR):
              state_n = BRANCH;
            default:
              ctrl.illegal_instr = 1'b1;
          endcase
        end
      end
      EXECR, EXECI: begin
        ctrl.alu_src_b   = (state == EXECI) ? SRCB_IMM : SRCB_REG;
        ctrl.alu_control = alu_op(cmd);
        // logical ops leave C and V untouched
        if (funct[0] || is_cmp) begin
          flags_d[3:2] = ctrl.alu_flags[3:2];
          if (arith) flags_d[1:0] = ctrl.alu_flags[1:0];
        end
        state_n = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        state_n        = FETCH;
      end
      MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
        state_n        = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.adr_src = 1'b1;
        state_n      = MEMWB;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_DATA;
        state_n         = FETCH;
      end
      MEMWR: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        state_n        = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_ALUOUT;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.pc_write   = 1'b1;
        state_n         = FETCH;
      end
      default: state_n = FETCH;
    endcase
    if (reset) begin
      ctrl.pc_write      = 1'b0;
      ctrl.adr_src       = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.alu_src_a     = 2'b00;
      ctrl.alu_src_b     = 2'b00;
      ctrl.result_src    = 2'b00;
      ctrl.alu_control   = ALU_ADD;
      ctrl.illegal_instr = 1'b0;
      state_n            = FETCH;
      flags_d            = '0;
    end
  end

  assign ctrl.flags_q   = flags_r;
  assign ctrl.state_dbg = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm and cond_unit.
module tb_cpu_control_fsm;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail   = 0;

  cpu_control_fsm_if bus ();

  cpu_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  logic [3:0] cu_cond;
  logic [3:0] cu_flags;
  logic       cu_ex;

  cond_unit u_cu (
    .cond    (cu_cond),
    .flags   (cu_flags),
    .cond_ex (cu_ex)
  );

  always #5 clk = ~clk;

  // {pc_w, adr, mem_w, ir_w, reg_w, src_a, src_b, res, alu, ill}
  logic [15:0] ctl;
  assign ctl = {bus.pc_write, bus.adr_src, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.result_src, bus.alu_control,
                bus.illegal_instr};

  localparam logic [15:0] C_ZERO  = 16'h0000;
  localparam logic [15:0] C_FETCH =
    {5'b10010, 2'b01, 2'b10, 2'b10, 4'h0, 1'b0};
  localparam logic [15:0] C_DEC =
    {5'b00000, 2'b01, 2'b10, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_DEC_ILL =
    {5'b00000, 2'b01, 2'b10, 2'b00, 4'h0, 1'b1};
  localparam logic [15:0] C_EXI_ADD =
    {5'b00000, 2'b00, 2'b01, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_EXR_SUB =
    {5'b00000, 2'b00, 2'b00, 2'b00, 4'h1, 1'b0};
  localparam logic [15:0] C_EXR_AND =
    {5'b00000, 2'b00, 2'b00, 2'b00, 4'h2, 1'b0};
  localparam logic [15:0] C_ALUWB =
    {5'b00001, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_MADR =
    {5'b00000, 2'b00, 2'b01, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_MRD =
    {5'b01000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_MWB =
    {5'b00001, 2'b00, 2'b00, 2'b01, 4'h0, 1'b0};
  localparam logic [15:0] C_MWR =
    {5'b01100, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0};
  localparam logic [15:0] C_BR =
    {5'b10000, 2'b10, 2'b01, 2'b10, 4'h0, 1'b0};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // check the current cycle at negedge, then move 1ns past next posedge
  task automatic step(input string tag,
                      input state_t st,
                      input logic [15:0] c);
    @(negedge clk);
    chk({tag, ".state"}, 32'(bus.state_dbg), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       ex;
  } cu_vec_t;

  cu_vec_t cu_tab[18] = '{
    '{4'h0, 4'b0100, 1'b1}, '{4'h0, 4'b0000, 1'b0},
    '{4'h1, 4'b0000, 1'b1}, '{4'h3, 4'b0010, 1'b0},
    '{4'h4, 4'b1000, 1'b1}, '{4'h5, 4'b1000, 1'b0},
    '{4'h6, 4'b0001, 1'b1}, '{4'h8, 4'b0010, 1'b1},
    '{4'h8, 4'b0110, 1'b0}, '{4'h9, 4'b0000, 1'b1},
    '{4'hA, 4'b1001, 1'b1}, '{4'hA, 4'b1000, 1'b0},
    '{4'hB, 4'b1000, 1'b1}, '{4'hC, 4'b0000, 1'b1},
    '{4'hC, 4'b0100, 1'b0}, '{4'hD, 4'b1000, 1'b1},
    '{4'hE, 4'b0110, 1'b1}, '{4'hF, 4'b1111, 1'b0}
  };

  initial begin
    reset         = 1'b1;
    bus.instr     = 32'h0;
    bus.alu_flags = 4'b0000;
    cu_cond       = 4'h0;
    cu_flags      = 4'h0;

    for (int i = 0; i < 18; i++) begin
      cu_cond  = cu_tab[i].cond;
      cu_flags = cu_tab[i].flags;
      #1;
      chk($sformatf("cond%0d", i), 32'(cu_ex), 32'(cu_tab[i].ex));
    end

    @(posedge clk);
    #1;
    step("rst0", FETCH, C_ZERO);
    chk("rst.flags", 32'(bus.flags_q), 32'h0);
    step("rst1", FETCH, C_ZERO);
    reset = 1'b0;

    // ADD R1,R2,#5 : S=0 so flags stay put
    bus.instr = 32'hE2821005;
    step("add.f", FETCH, C_FETCH);
    step("add.d", DECODE, C_DEC);
    bus.alu_flags = 4'b1111;
    step("add.x", EXECI, C_EXI_ADD);
    step("add.wb", ALUWB, C_ALUWB);
    chk("add.flags", 32'(bus.flags_q), 32'h0);

    // CMP R1,R2 sets Z; BEQ then taken
    bus.instr = 32'hE1510002;
    step("cmp.f", FETCH, C_FETCH);
    step("cmp.d", DECODE, C_DEC);
    bus.alu_flags = 4'b0100;
    step("cmp.x", EXECR, C_EXR_SUB);
    chk("cmp.flags", 32'(bus.flags_q), 32'h4);
    bus.instr = 32'h0A000001;
    step("beq.f", FETCH, C_FETCH);
    step("beq.d", DECODE, C_DEC);
    step("beq.br", BRANCH, C_BR);

    // CMP leaving Z=0, C=1; BEQ falls through as NOP
    bus.instr = 32'hE1510002;
    step("cmp2.f", FETCH, C_FETCH);
    step("cmp2.d", DECODE, C_DEC);
    bus.alu_flags = 4'b0010;
    step("cmp2.x", EXECR, C_EXR_SUB);
    chk("cmp2.flags", 32'(bus.flags_q), 32'h2);
    bus.instr = 32'h0A000001;
    step("nop.f", FETCH, C_FETCH);
    step("nop.d", DECODE, C_DEC);

    // ANDS: N,Z from ALU, C,V kept (0010 + 1011 -> 1010)
    bus.instr = 32'hE0121003;
    step("ands.f", FETCH, C_FETCH);
    step("ands.d", DECODE, C_DEC);
    bus.alu_flags = 4'b1011;
    step("ands.x", EXECR, C_EXR_AND);
    chk("ands.flags", 32'(bus.flags_q), 32'hA);
    step("ands.wb", ALUWB, C_ALUWB);

    // LDR: five cycles, flags untouched
    bus.instr     = 32'hE5910004;
    bus.alu_flags = 4'b0101;
    step("ldr.f", FETCH, C_FETCH);
    step("ldr.d", DECODE, C_DEC);
    step("ldr.a", MEMADR, C_MADR);
    step("ldr.rd", MEMRD, C_MRD);
    step("ldr.wb", MEMWB, C_MWB);
    chk("ldr.flags", 32'(bus.flags_q), 32'hA);

    // STR: single mem_write cycle
    bus.instr = 32'hE5810004;
    step("str.f", FETCH, C_FETCH);
    step("str.d", DECODE, C_DEC);
    step("str.a", MEMADR, C_MADR);
    step("str.wr", MEMWR, C_MWR);

    // op=11 is illegal
    bus.instr = 32'hEE000000;
    step("ill.f", FETCH, C_FETCH);
    step("ill.d", DECODE, C_DEC_ILL);

    // ADD to R15 is rejected in DECODE
    bus.instr = 32'hE282F005;
    step("pc.f", FETCH, C_FETCH);
    step("pc.d", DECODE, C_DEC_ILL);

    // reset landing on MEMWR suppresses the write
    bus.instr = 32'hE5810004;
    step("srst.f", FETCH, C_FETCH);
    step("srst.d", DECODE, C_DEC);
    step("srst.a", MEMADR, C_MADR);
    reset = 1'b1;
    step("srst.wr", MEMWR, C_ZERO);
    reset = 1'b0;
    chk("srst.flags", 32'(bus.flags_q), 32'h0);
    step("srst.f2", FETCH, C_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multicycle main controller for the ARM-subset CPU datapath. It covers the program counter, instruction memory/IR, register file, ALU and data memory. Each instruction is sequenced through FETCH/DECODE/EXECUTE/WRITEBACK states. The block drives every datapath enable and mux select, and holds the NZCV flags register with ARM condition-code evaluation. It sits beside the datapath in the CPU top level and replaces the hard-wired we3 and alu_control constants.

Parameters:
ALU_CTRL_W, 4, width of the ALU control bus (matches the ALU alucontrol port)
FLAGS_W, 4, width of the ALU flags bus, ordered N,Z,C,V from MSB to LSB

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr  input  32  current IR contents; cond[31:28], op[27:26], funct[25:20], rd[15:12]
alu_flags  input  4  NZCV from the ALU result of the current cycle
pc_write  output  1  load the PC
adr_src  output  1  memory address select: 0=PC, 1=ALU result register
mem_write  output  1  data memory write enable
ir_write  output  1  load the instruction register
reg_write  output  1  register file WE3
alu_src_a  output  2  00=RD1 reg, 01=PC, 10=ALU out reg
alu_src_b  output  2  00=RD2 reg, 01=extended imm, 10=constant 4
result_src  output  2  00=ALU out reg, 01=data reg, 10=ALU result (direct)
alu_control  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR
flags_q  output  4  architectural NZCV register
illegal_instr  output  1  one-cycle pulse in DECODE on an unsupported encoding
state_dbg  output  4  current state encoding, for debug

Behaviour:
- One clock, clk. Reset is synchronous and active-high; the reset port is named reset.
- While reset=1 at a clk edge: state<=FETCH, flags_q<=0. While reset is high, all enables (pc_write, ir_write, reg_write, mem_write, illegal_instr) are forced to 0 and selects are forced to 0.
- Reset asserted mid-instruction aborts it. No write enable may assert in the cycle reset is high.
- Outputs are Moore-style decodes of state. In DECODE they are also qualified by instr, combinationally.
- FETCH: ir_write=1, adr_src=0, alu_src_a=01, alu_src_b=10, alu_control=ADD, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=10, ADD (PC+8). Evaluate cond_ex from instr[31:28] and flags_q, using all 15 ARM conditions; 1111 is treated as false.
  - cond_ex=0 -> FETCH, no side effects (instruction becomes a NOP).
  - op=00 & funct[5]=0 -> EXECR; op=00 & funct[5]=1 -> EXECI.
  - op=01 -> MEMADR.
  - op=10 -> BRANCH.
  - op=11, or an unsupported cmd -> illegal_instr=1 and next state FETCH.
- Supported cmd (funct[4:1]): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
  - CMP uses SUB with S forced to 1 and no writeback.
- EXECR / EXECI: alu_src_a=00, alu_src_b=00 (EXECR) or 01 (EXECI).
  - If funct[0]=1 or cmd=CMP: flags_q<=alu_flags at the end of the cycle.
  - C and V update only for ADD/SUB/CMP; N and Z always update.
  - Next state: ALUWB, or FETCH when cmd=CMP.
- ALUWB: reg_write=1, result_src=00. Next state is FETCH.
- MEMADR: alu_src_a=00, alu_src_b=01, ADD (U bit ignored, positive offset only).
  - funct[0]=1 (LDR) -> MEMRD; otherwise -> MEMWR.
- MEMRD: adr_src=1. Next state is MEMWB.
- MEMWB: reg_write=1, result_src=01. Next state is FETCH.
- MEMWR: adr_src=1, mem_write=1. Next state is FETCH.
- BRANCH: alu_src_a=10, alu_src_b=01, ADD, result_src=10, pc_write=1. Next state is FETCH. BL is not supported; it is treated as B.
- Latency in cycles:
  - data-processing: 4
  - CMP: 3
  - LDR: 5
  - STR: 4
  - B: 3
  - condition-failed or illegal: 2
- Writes to rd=15 from ALUWB/MEMWB are not supported. Instead: reg_write is suppressed, illegal_instr pulses in DECODE, and the next state is FETCH.
- Flags change only at EXEC states. They are never changed by memory or branch instructions.

Decomposition:
- Package cpu_ctrl_pkg:
  - state_t enum: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH.
  - ALU_ADD/SUB/AND/ORR constants.
  - cmd and cond code constants.
  - mux-select localparams.
- Sub-module cond_unit (combinational): inputs cond[3:0] and flags[3:0], output cond_ex. It is tested standalone as well.

Test Plan:
- Reset held 2 cycles, then released -> state_dbg=FETCH, all enables 0 during reset, flags_q=0000, then ir_write=pc_write=1 in the first cycle after release.
- instr=E2821005 (ADD R1,R2,#5) -> FETCH, DECODE, EXECI (alu_src_b=01, ADD), ALUWB (reg_write=1), back to FETCH; flags_q unchanged.
- instr=E1510002 (CMP R1,R2) with alu_flags=0100 driven in EXECR -> flags_q=0100 after EXECR, no reg_write, then FETCH; a following 0A000001 (BEQ) enters BRANCH with pc_write=1.
- flags_q=0000 with instr=0A000001 (BEQ) -> FETCH, DECODE, FETCH; pc_write only in FETCH, no reg_write/mem_write.
- instr=E5910004 (LDR) -> MEMADR, MEMRD (adr_src=1), MEMWB (reg_write=1, result_src=01), 5 cycles total. instr=E5810004 (STR) -> MEMWR with mem_write=1 for exactly one cycle.
- instr=EE000000 (op=11) -> illegal_instr pulses once in DECODE, then FETCH. A reset asserted during MEMWR -> mem_write=0 that cycle, then FETCH.
